// File: rtl/ring_buffer_axi_responder_if.sv
// rtl/ring_buffer_axi_responder_if.sv - AXI4 read-only AR/R bundle between correlator master and ring buffer
interface ring_buffer_axi_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arlen, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/ring_buffer_axi_responder.sv
// rtl/ring_buffer_axi_responder.sv - per-channel sample ring buffer answering AXI4 read bursts
module ring_buffer_axi_responder #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                              clk,
  input  logic                              reset_b,
  input  logic [DATA_W-1:0]                 sample_in,
  input  logic                              sample_valid,
  input  logic                              freeze,
  output logic [ADDR_W-1:0]                 wr_ptr,
  output logic                              buf_full,
  ring_buffer_axi_responder_if.slave        axi
);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mem_q;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        cnt;
  logic              err;
  logic              wr_en;
  logic              ar_hs;
  logic              r_hs;

  assign wr_en = sample_valid && !freeze;
  assign ar_hs = axi.arvalid && axi.arready;
  assign r_hs  = axi.rvalid && axi.rready;

  // In STREAM, addr is the index already sitting in mem_q; re-reading it on a stall acts as the skid.
  always_comb begin
    rd_addr = addr;
    case (state)
      IDLE:    rd_addr = axi.araddr;
      FETCH:   rd_addr = addr + ADDR_W'(1);
      STREAM:  rd_addr = r_hs ? addr + ADDR_W'(1) : addr;
      default: rd_addr = addr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= sample_in;
    end
    mem_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr      <= '0;
      buf_full    <= 1'b0;
      state       <= IDLE;
      addr        <= '0;
      cnt         <= '0;
      err         <= 1'b0;
      axi.arready <= 1'b0;
      axi.rvalid  <= 1'b0;
      axi.rlast   <= 1'b0;
      axi.rresp   <= 2'b00;
      axi.rdata   <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        if (wr_ptr == ADDR_W'(DEPTH - 1)) begin
          buf_full <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          axi.arready <= 1'b1;
          if (ar_hs) begin
            addr        <= axi.araddr;
            cnt         <= axi.arlen;
            err         <= !freeze;
            axi.arready <= 1'b0;
            state       <= FETCH;
          end
        end
        FETCH: begin
          axi.rvalid <= 1'b1;
          axi.rdata  <= mem_q;
          axi.rresp  <= err ? 2'b10 : 2'b00;
          axi.rlast  <= (cnt == 8'd0);
          addr       <= addr + ADDR_W'(1);
          state      <= STREAM;
        end
        STREAM: begin
          if (r_hs) begin
            if (axi.rlast) begin
              axi.rvalid  <= 1'b0;
              axi.rlast   <= 1'b0;
              axi.arready <= 1'b1;
              state       <= IDLE;
            end else begin
              axi.rdata <= mem_q;
              axi.rlast <= (cnt == 8'd1);
              addr      <= addr + ADDR_W'(1);
              cnt       <= cnt - 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_buffer_axi_responder.sv
// tb/tb_ring_buffer_axi_responder.sv - directed vector bench for ring_buffer_axi_responder
module tb_ring_buffer_axi_responder;

  logic        clk;
  logic        reset_b;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        freeze;
  logic [9:0]  wr_ptr;
  logic        buf_full;

  ring_buffer_axi_responder_if #(.DATA_W(16), .ADDR_W(10)) bus ();

  ring_buffer_axi_responder #(.DATA_W(16), .DEPTH(1024)) dut (
    .clk          (clk),
    .reset_b      (reset_b),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .freeze       (freeze),
    .wr_ptr       (wr_ptr),
    .buf_full     (buf_full),
    .axi          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc_cnt = 0;
  bit auto_wr = 0;

  // Reference RAM contents, written under the same gating the buffer must apply.
  logic [15:0] m_mem [1024];
  logic [9:0]  m_wp;
  always @(posedge clk or negedge reset_b) begin
    if (!reset_b) m_wp <= '0;
    else if (sample_valid && !freeze) begin
      m_mem[m_wp] <= sample_in;
      m_wp <= m_wp + 10'd1;
    end
  end

  typedef struct {
    logic [9:0]  araddr;
    logic [7:0]  arlen;
    int          mode;
    logic [1:0]  resp;
    logic [15:0] first;
    logic [15:0] last;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc_cnt++;
    if (auto_wr) sample_in = sample_in + 16'd1;
  endtask

  function automatic bit rr_pattern(input int mode, input int c);
    bit p [6];
    p = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    if (mode == 0) return 1'b1;
    return p[c % 6];
  endfunction

  task automatic do_burst(input logic [9:0] a, input logic [7:0] len, input int mode,
                          input logic [1:0] exp_resp, input bit chk_data,
                          output logic [15:0] first_d, output logic [15:0] last_d);
    int beats, c;
    bit stalled;
    bit rr;
    logic [15:0] hd;
    logic hl;
    logic [9:0] ix;
    first_d = 'x;
    last_d  = 'x;
    bus.araddr  = a;
    bus.arlen   = len;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b0;
    c = 0;
    while (bus.arready !== 1'b1 && c < 20) begin
      step();
      c++;
    end
    if (bus.arready !== 1'b1) begin
      chk("ar_wait_timeout", 32'(bus.arready), 32'd1);
      bus.arvalid = 1'b0;
      return;
    end
    step();
    bus.arvalid = 1'b0;
    chk("fetch_rvalid", 32'(bus.rvalid), 32'd0);
    chk("fetch_arready", 32'(bus.arready), 32'd0);
    beats = 0;
    c = 0;
    stalled = 0;
    while (beats <= int'(len) && c < 3000) begin
      step();
      if (mode == 0) chk("no_gap_rvalid", 32'(bus.rvalid), 32'd1);
      if (bus.arready !== 1'b0) chk("busy_arready", 32'(bus.arready), 32'd0);
      if (stalled) begin
        chk("stall_rvalid", 32'(bus.rvalid), 32'd1);
        chk("stall_rdata", 32'(bus.rdata), 32'(hd));
        chk("stall_rlast", 32'(bus.rlast), 32'(hl));
      end
      rr = rr_pattern(mode, c);
      bus.rready = rr;
      if (bus.rvalid === 1'b1) begin
        if (rr) begin
          ix = a + 10'(beats);
          chk("beat_rlast", 32'(bus.rlast), 32'(beats == int'(len)));
          chk("beat_rresp", 32'(bus.rresp), 32'(exp_resp));
          if (chk_data) chk("beat_rdata", 32'(bus.rdata), 32'(m_mem[ix]));
          if (beats == 0) first_d = bus.rdata;
          last_d = bus.rdata;
          beats++;
          stalled = 0;
        end else begin
          stalled = 1;
          hd = bus.rdata;
          hl = bus.rlast;
        end
      end
      c++;
    end
    if (beats <= int'(len)) chk("burst_timeout_beats", 32'(beats), 32'(len) + 32'd1);
    step();
    bus.rready = 1'b0;
    chk("post_rvalid", 32'(bus.rvalid), 32'd0);
    chk("post_rlast", 32'(bus.rlast), 32'd0);
    chk("post_arready", 32'(bus.arready), 32'd1);
  endtask

  initial begin
    logic [15:0] f, l;
    int c0;
    logic [9:0] wp4;

    vecs[0] = '{10'd768,  8'd255, 0, 2'b00, 16'd768,  16'd1023};
    vecs[1] = '{10'd1000, 8'd49,  0, 2'b00, 16'd1000, 16'd25};
    vecs[2] = '{10'd10,   8'd7,   1, 2'b00, 16'd10,   16'd17};
    vecs[3] = '{10'd0,    8'd0,   1, 2'b00, 16'd0,    16'd0};
    vecs[4] = '{10'd1023, 8'd1,   0, 2'b00, 16'd1023, 16'd0};

    reset_b = 1'b0;
    sample_in = '0;
    sample_valid = 1'b0;
    freeze = 1'b0;
    bus.araddr = '0;
    bus.arlen = '0;
    bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    step();
    step();
    chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("rst_buf_full", 32'(buf_full), 32'd0);
    chk("rst_arready", 32'(bus.arready), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_rlast", 32'(bus.rlast), 32'd0);
    chk("rst_rresp", 32'(bus.rresp), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    reset_b = 1'b1;
    step();
    chk("rel_arready", 32'(bus.arready), 32'd1);

    sample_valid = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      sample_in = 16'(i);
      if (i == 1023) begin
        chk("pre_wrap_buf_full", 32'(buf_full), 32'd0);
        chk("pre_wrap_wr_ptr", 32'(wr_ptr), 32'd1023);
      end
      step();
    end
    sample_valid = 1'b0;
    freeze = 1'b1;
    chk("fill_buf_full", 32'(buf_full), 32'd1);
    chk("fill_wr_ptr", 32'(wr_ptr), 32'd0);

    for (int v = 0; v < 5; v++) begin
      do_burst(vecs[v].araddr, vecs[v].arlen, vecs[v].mode, vecs[v].resp, 1'b1, f, l);
      chk($sformatf("vec%0d_first", v), 32'(f), 32'(vecs[v].first));
      chk($sformatf("vec%0d_last", v), 32'(l), 32'(vecs[v].last));
    end

    // Not frozen: SLVERR for the whole burst while samples keep landing.
    freeze = 1'b0;
    sample_valid = 1'b1;
    sample_in = 16'h4000;
    auto_wr = 1;
    c0 = cyc_cnt;
    do_burst(10'd900, 8'd3, 0, 2'b10, 1'b0, f, l);
    wp4 = 10'(cyc_cnt - c0);
    chk("nofreeze_wr_ptr", 32'(wr_ptr), 32'(wp4));
    sample_valid = 1'b0;
    auto_wr = 0;

    // Freeze gating: writes requested but ignored.
    freeze = 1'b1;
    sample_valid = 1'b1;
    sample_in = 16'hdead;
    for (int i = 0; i < 20; i++) step();
    sample_valid = 1'b0;
    chk("freeze_wr_ptr", 32'(wr_ptr), 32'(wp4));
    do_burst(wp4, 8'd3, 0, 2'b00, 1'b1, f, l);
    chk("freeze_ram_first", 32'(f), 32'(wp4));
    chk("freeze_ram_last", 32'(l), 32'(wp4) + 32'd3);

    // Reset on the third beat of a 16-beat burst.
    chk("t6_arready", 32'(bus.arready), 32'd1);
    bus.araddr = 10'd500;
    bus.arlen = 8'd15;
    bus.arvalid = 1'b1;
    bus.rready = 1'b1;
    step();
    bus.arvalid = 1'b0;
    step();
    chk("t6_beat1", 32'(bus.rdata), 32'd500);
    step();
    chk("t6_beat2", 32'(bus.rdata), 32'd501);
    step();
    chk("t6_beat3_rvalid", 32'(bus.rvalid), 32'd1);
    chk("t6_beat3", 32'(bus.rdata), 32'd502);
    reset_b = 1'b0;
    #1;
    chk("t6_rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("t6_rst_arready", 32'(bus.arready), 32'd0);
    chk("t6_rst_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("t6_rst_buf_full", 32'(buf_full), 32'd0);
    bus.rready = 1'b0;
    step();
    reset_b = 1'b1;
    step();
    chk("t6_rel_arready", 32'(bus.arready), 32'd1);
    do_burst(10'd500, 8'd15, 0, 2'b00, 1'b1, f, l);
    chk("t6_after_first", 32'(f), 32'd500);
    chk("t6_after_last", 32'(l), 32'd515);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ring_buffer_axi_responder.md
Name: ring_buffer_axi_responder

Overview:
- Per-channel sample ring buffer written continuously by the hydrophone sample path.
- Answers AXI4 read bursts (AR/R channels only) from the cross-correlation pipeline's AXI master, which fetches a 256-sample window per channel for the FFTs.
- One instance per hydrophone channel.
- A freeze input holds the buffer contents stable while a correlation window is read.

Parameters:
- DATA_W, 16: sample width and rdata width.
- DEPTH, 1024: ring depth in samples; must be a power of two.
- ADDR_W, $clog2(DEPTH): width of the sample index.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_b  input  1  asynchronous, active-low reset.
- sample_in  input  DATA_W  incoming ADC sample.
- sample_valid  input  1  write sample_in at wr_ptr this cycle.
- freeze  input  1  1 = ignore sample_valid; buffer contents are held.
- wr_ptr  output  ADDR_W  next physical write index.
- buf_full  output  1  sticky; set once wr_ptr has wrapped.
- araddr  input  ADDR_W  physical start index of the burst.
- arlen  input  8  number of beats minus 1 (1 to 256 beats).
- arvalid  input  1  read-address valid.
- arready  output  1  read-address ready.
- rdata  output  DATA_W  read data.
- rresp  output  2  00 = OKAY, 10 = SLVERR.
- rlast  output  1  final beat of the burst.
- rvalid  output  1  read-data valid.
- rready  input  1  read-data ready.

Behaviour:
Reset values and reset rules:
- reset_b low: wr_ptr=0, buf_full=0, arready=0, rvalid=0, rlast=0, rresp=00, rdata=0, FSM=IDLE.
- RAM contents are not cleared.
- Reset asserted mid-burst aborts the burst immediately; there is no completion beat.

Write side:
- If sample_valid && !freeze: mem[wr_ptr] <= sample_in and wr_ptr <= wr_ptr+1, modulo DEPTH.
- On the transition DEPTH-1 -> 0, buf_full is set to 1 and stays set until reset.

RAM:
- Single-clock RAM with a synchronous read port, 1-cycle latency.
- Read-during-write to the same index returns the old data (read-first).

FSM states: IDLE, FETCH, STREAM.
- IDLE:
  - arready=1.
  - On arvalid && arready: latch addr=araddr and cnt=arlen.
  - Latch err = !freeze (SLVERR for the whole burst when the buffer was not frozen at acceptance).
  - Issue a RAM read at araddr and go to FETCH.
- FETCH:
  - arready=0.
  - Next cycle: rvalid=1, rdata=mem[addr], rresp=err ? 10 : 00, rlast=(cnt==0).
  - Also pre-issue a read of addr+1 and go to STREAM.
- STREAM:
  - rvalid && !rready: rdata, rresp and rlast are held stable. The RAM read address is held, with a skid register if needed. No beat is lost or duplicated.
  - rvalid && rready && !rlast: advance addr (wrapping DEPTH-1 -> 0), cnt--, present the next beat on the following cycle. There are no bubbles.
  - rvalid && rready && rlast: rvalid=0 and rlast=0 next cycle; go to IDLE.

Latency and throughput:
- AR handshake in cycle T -> first beat has rvalid=1 in cycle T+2.
- With rready held at 1, one beat is transferred per cycle.
- Burst of L beats: the final handshake is in cycle T+1+L; arready=1 again in cycle T+2+L.

Address rules:
- Burst addresses wrap modulo DEPTH; no 4 KB or AXI boundary rules apply.
- araddr is physical. The master computes it as wr_ptr-256 (mod DEPTH) for the latest window.

Other rules:
- Writes may continue during a burst when freeze=0; the data is then not guaranteed coherent, which SLVERR signals.
- A change of freeze mid-burst does not alter rresp.
- Only one outstanding burst is allowed; arready=0 outside IDLE.
- rresp never takes the values 01 or 11.

Test Plan:
1. Write 0..1023 (sample_in=index), then freeze=1; AR araddr=768, arlen=255, rready=1 -> 256 beats with rdata 768..1023, rresp=00, rlast only on beat 256, first rvalid 2 cycles after AR, no gaps; buf_full=1, wr_ptr=0.
2. Wrap: freeze=1, araddr=1000, arlen=49 -> rdata 1000..1023 then 0..25; rlast on the 50th beat.
3. Backpressure: araddr=10, arlen=7, rready toggles 1,0,0,1,0,1,… -> rdata/rlast stable while stalled; exactly values 10..17 delivered once each, in order.
4. Not frozen: freeze=0 with sample_valid=1 every cycle; AR arlen=3 -> 4 beats, all with rresp=10; wr_ptr advances by 1 per cycle; arready=0 until one cycle after the rlast handshake.
5. Freeze gating: freeze=1, sample_valid=1 for 20 cycles -> wr_ptr unchanged, RAM unchanged (verified by a subsequent read).
6. Reset mid-burst: assert reset_b=0 on beat 3 of an arlen=15 burst -> rvalid=0, arready=0, wr_ptr=0, buf_full=0 immediately; after release: arready=1 next cycle, and a new burst (freeze=1) returns 00 rresp and the previously written RAM data.
